// File: rtl/riscv_mem_pkg.sv
// Shared encodings and widths for the RAM-port arbiter.
package riscv_mem_pkg;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACCESS = 1'b1
   } state_t;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_D  = 1'b1
   } owner_t;

   // Wide enough for the largest allowed streak limit (15).
   localparam int STREAK_W = 4;
   // Wide enough for the largest allowed read latency (3).
   localparam int CNT_W    = 2;

endpackage

// File: rtl/riscv_mem_prio.sv
// Requester selection: data first, fetch forced after MAX_DATA_STREAK data wins while fetch waits.
// Grant is combinational from the requests and only while idle; the streak counter is registered.
module riscv_mem_prio
   import riscv_mem_pkg::*;
#(
   parameter int MAX_DATA_STREAK = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       if_req,
   input  logic       d_req,
   input  logic       idle,
   output logic [1:0] gnt
);

   localparam logic [STREAK_W-1:0] STREAK_LIM = STREAK_W'(MAX_DATA_STREAK);
   localparam logic [STREAK_W-1:0] STREAK_SAT = '1;

   logic [STREAK_W-1:0] streak_q;

   always_comb begin
      gnt = 2'b00;
      if (idle) begin
         if (if_req && d_req) begin
            if (streak_q == STREAK_LIM) gnt[OWN_IF] = 1'b1;
            else                        gnt[OWN_D]  = 1'b1;
         end else if (if_req) begin
            gnt[OWN_IF] = 1'b1;
         end else if (d_req) begin
            gnt[OWN_D] = 1'b1;
         end
      end
   end

   // The streak only counts data wins that happen while fetch is actually waiting.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         streak_q <= '0;
      end else if (gnt[OWN_IF]) begin
         streak_q <= '0;
      end else if (gnt[OWN_D]) begin
         if (!if_req)                     streak_q <= '0;
         else if (streak_q != STREAK_SAT) streak_q <= streak_q + STREAK_W'(1);
      end
   end

endmodule

// File: rtl/riscv_mem_arbiter.sv
// Shares one RAM port between instruction fetch and load/store, one transaction in flight.
// Read done at grant+1+RD_LATENCY, write done at grant+1; requests are ignored (no grant) while busy.
module riscv_mem_arbiter
   import riscv_mem_pkg::*;
#(
   parameter int ADDR_W          = 32,
   parameter int DATA_W          = 32,
   parameter int RD_LATENCY      = 1,
   parameter int MAX_DATA_STREAK = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req_i,
   input  logic [ADDR_W-1:0] if_addr_i,
   output logic              if_gnt_o,
   output logic              if_done_o,
   output logic [DATA_W-1:0] if_rdata_o,
   input  logic              d_req_i,
   input  logic              d_we_i,
   input  logic [ADDR_W-1:0] d_addr_i,
   input  logic [DATA_W-1:0] d_wdata_i,
   output logic              d_gnt_o,
   output logic              d_done_o,
   output logic [DATA_W-1:0] d_rdata_o,
   output logic              we_o,
   output logic [ADDR_W-1:0] addr_o,
   output logic [DATA_W-1:0] data_o,
   input  logic [DATA_W-1:0] data_i,
   output logic              busy_o
);

   localparam logic [CNT_W-1:0] LAT = CNT_W'(RD_LATENCY);

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   owner_t             owner_q;
   logic [ADDR_W-1:0]  addr_q;
   logic [DATA_W-1:0]  wdata_q;
   logic               we_q;
   logic [1:0]         gnt;
   logic               done;

   riscv_mem_prio #(
      .MAX_DATA_STREAK (MAX_DATA_STREAK)
   ) u_prio (
      .clk    (clk),
      .reset  (reset),
      .if_req (if_req_i),
      .d_req  (d_req_i),
      .idle   (state_q == ST_IDLE),
      .gnt    (gnt)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      done    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (|gnt) begin
               state_d = ST_ACCESS;
               cnt_d   = '0;
            end
         end
         ST_ACCESS: begin
            if (we_q || cnt_q == LAT) begin
               done    = 1'b1;
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Write data is only captured for data grants so data_o keeps its last store value across fetches.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         owner_q <= OWN_IF;
         addr_q  <= '0;
         we_q    <= 1'b0;
         wdata_q <= '0;
      end else if (gnt[OWN_D]) begin
         owner_q <= OWN_D;
         addr_q  <= d_addr_i;
         we_q    <= d_we_i;
         wdata_q <= d_wdata_i;
      end else if (gnt[OWN_IF]) begin
         owner_q <= OWN_IF;
         addr_q  <= if_addr_i;
         we_q    <= 1'b0;
      end
   end

   assign if_gnt_o   = gnt[OWN_IF];
   assign d_gnt_o    = gnt[OWN_D];
   assign busy_o     = (state_q == ST_ACCESS);
   assign we_o       = busy_o && we_q;
   assign addr_o     = addr_q;
   assign data_o     = wdata_q;
   assign if_done_o  = done && (owner_q == OWN_IF);
   assign d_done_o   = done && (owner_q == OWN_D);
   assign if_rdata_o = data_i;
   assign d_rdata_o  = data_i;

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Directed bench for riscv_mem_arbiter: one DUT at RD_LATENCY=1 and a load-only DUT at RD_LATENCY=3.
module tb_riscv_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   always #5 clk = ~clk;

   logic        if_req, if_gnt, if_done;
   logic [31:0] if_addr, if_rdata;
   logic        d_req, d_we, d_gnt, d_done;
   logic [31:0] d_addr, d_wdata, d_rdata;
   logic        we, busy;
   logic [31:0] addr, wdat, rdat;

   logic        if_req3, if_gnt3, if_done3;
   logic [31:0] if_addr3, if_rdata3;
   logic        d_req3, d_we3, d_gnt3, d_done3;
   logic [31:0] d_addr3, d_wdata3, d_rdata3;
   logic        we3, busy3;
   logic [31:0] addr3, wdat3, rdat3;

   logic [31:0] mem  [0:4095];
   logic [31:0] mem3 [0:4095];

   int vec_cnt = 0;
   int err_cnt = 0;

   riscv_mem_arbiter dut (
      .clk(clk), .reset(reset),
      .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt), .if_done_o(if_done), .if_rdata_o(if_rdata),
      .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
      .d_gnt_o(d_gnt), .d_done_o(d_done), .d_rdata_o(d_rdata),
      .we_o(we), .addr_o(addr), .data_o(wdat), .data_i(rdat), .busy_o(busy)
   );

   riscv_mem_arbiter #(.RD_LATENCY(3)) dut3 (
      .clk(clk), .reset(reset),
      .if_req_i(if_req3), .if_addr_i(if_addr3), .if_gnt_o(if_gnt3), .if_done_o(if_done3), .if_rdata_o(if_rdata3),
      .d_req_i(d_req3), .d_we_i(d_we3), .d_addr_i(d_addr3), .d_wdata_i(d_wdata3),
      .d_gnt_o(d_gnt3), .d_done_o(d_done3), .d_rdata_o(d_rdata3),
      .we_o(we3), .addr_o(addr3), .data_o(wdat3), .data_i(rdat3), .busy_o(busy3)
   );

   // Word-addressed RAM models; read data is available as soon as the address is.
   assign rdat  = mem[addr[13:2]];
   assign rdat3 = mem3[addr3[13:2]];
   always @(posedge clk) if (we)  mem[addr[13:2]]   <= wdat;
   always @(posedge clk) if (we3) mem3[addr3[13:2]] <= wdat3;

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      vec_cnt++; if (we !== 1'b0)    begin err_cnt++; $display("FAIL reset_we got %b want 0", we); end
      vec_cnt++; if (addr !== 32'h0) begin err_cnt++; $display("FAIL reset_addr got %h want 0", addr); end
      vec_cnt++; if (wdat !== 32'h0) begin err_cnt++; $display("FAIL reset_data got %h want 0", wdat); end
      vec_cnt++; if (busy !== 1'b0)  begin err_cnt++; $display("FAIL reset_busy got %b want 0", busy); end
      vec_cnt++; if ({if_gnt, d_gnt, if_done, d_done} !== 4'b0)
         begin err_cnt++; $display("FAIL reset_gnt_done got %b want 0000", {if_gnt, d_gnt, if_done, d_done}); end
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_fetch();
      @(negedge clk);
      if_req = 1'b1; if_addr = 32'h100;
      #1;
      vec_cnt++; if ({if_gnt, d_gnt} !== 2'b10) begin err_cnt++; $display("FAIL fetch_gnt got %b want 10", {if_gnt, d_gnt}); end
      @(negedge clk);
      if_req = 1'b0; if_addr = 32'hFFFF_FFFF;
      #1;
      vec_cnt++; if (addr !== 32'h100) begin err_cnt++; $display("FAIL fetch_addr_t1 got %h want 100", addr); end
      vec_cnt++; if ({busy, if_done, we} !== 3'b100) begin err_cnt++; $display("FAIL fetch_t1 busy/done/we got %b want 100", {busy, if_done, we}); end
      @(negedge clk); #1;
      vec_cnt++; if (if_done !== 1'b1) begin err_cnt++; $display("FAIL fetch_done got %b want 1", if_done); end
      vec_cnt++; if (if_rdata !== 32'h00500093) begin err_cnt++; $display("FAIL fetch_rdata got %h want 00500093", if_rdata); end
      vec_cnt++; if (addr !== 32'h100) begin err_cnt++; $display("FAIL fetch_addr_t2 got %h want 100", addr); end
      vec_cnt++; if (d_done !== 1'b0) begin err_cnt++; $display("FAIL fetch_no_ddone got %b want 0", d_done); end
      @(negedge clk); #1;
      vec_cnt++; if ({busy, if_done} !== 2'b00) begin err_cnt++; $display("FAIL fetch_t3 busy/done got %b want 00", {busy, if_done}); end
   endtask

   task automatic test_store_load();
      @(negedge clk);
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000; d_wdata = 32'hDEADBEEF;
      #1;
      vec_cnt++; if ({if_gnt, d_gnt} !== 2'b01) begin err_cnt++; $display("FAIL store_gnt got %b want 01", {if_gnt, d_gnt}); end
      vec_cnt++; if (we !== 1'b0) begin err_cnt++; $display("FAIL store_we_t0 got %b want 0", we); end
      @(negedge clk);
      d_req = 1'b0; d_we = 1'b0; d_wdata = 32'h0;
      #1;
      vec_cnt++; if ({we, d_done} !== 2'b11) begin err_cnt++; $display("FAIL store_t1 we/done got %b want 11", {we, d_done}); end
      vec_cnt++; if (addr !== 32'h2000) begin err_cnt++; $display("FAIL store_addr got %h want 2000", addr); end
      vec_cnt++; if (wdat !== 32'hDEADBEEF) begin err_cnt++; $display("FAIL store_data got %h want deadbeef", wdat); end
      @(negedge clk); #1;
      vec_cnt++; if ({we, d_done, busy} !== 3'b000) begin err_cnt++; $display("FAIL store_t2 we/done/busy got %b want 000", {we, d_done, busy}); end
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2000;
      #1;
      vec_cnt++; if (d_gnt !== 1'b1) begin err_cnt++; $display("FAIL load_gnt got %b want 1", d_gnt); end
      @(negedge clk);
      d_req = 1'b0;
      #1;
      vec_cnt++; if ({we, d_done} !== 2'b00) begin err_cnt++; $display("FAIL load_t1 we/done got %b want 00", {we, d_done}); end
      @(negedge clk); #1;
      vec_cnt++; if ({d_done, if_done} !== 2'b10) begin err_cnt++; $display("FAIL load_done got %b want 10", {d_done, if_done}); end
      vec_cnt++; if (d_rdata !== 32'hDEADBEEF) begin err_cnt++; $display("FAIL load_rdata got %h want deadbeef", d_rdata); end
      @(negedge clk);
   endtask

   task automatic test_streak();
      string order;
      string expect_order;
      int    n;
      order = "";
      expect_order = "DDDDIDDDDI";
      n = 0;
      @(negedge clk);
      if_req = 1'b1; if_addr = 32'h100;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
      for (int c = 0; c < 200 && n < 10; c++) begin
         if (c != 0) @(negedge clk);
         #1;
         vec_cnt++;
         if (if_gnt && d_gnt) begin err_cnt++; $display("FAIL streak_double_gnt cycle %0d got 11 want one-hot", c); end
         if (d_gnt)  begin order = {order, "D"}; n++; end
         else if (if_gnt) begin order = {order, "I"}; n++; end
      end
      @(negedge clk);
      if_req = 1'b0; d_req = 1'b0;
      vec_cnt++; if (n != 10) begin err_cnt++; $display("FAIL streak_count got %0d want 10", n); end
      vec_cnt++; if (order != expect_order) begin err_cnt++; $display("FAIL streak_order got %s want %s", order, expect_order); end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_lat3();
      @(negedge clk);
      d_req3 = 1'b1; d_we3 = 1'b0; d_addr3 = 32'h40;
      #1;
      vec_cnt++; if (d_gnt3 !== 1'b1) begin err_cnt++; $display("FAIL lat3_gnt got %b want 1", d_gnt3); end
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         d_req3 = 1'b0; d_addr3 = 32'h0;
         #1;
         vec_cnt++; if (addr3 !== 32'h40) begin err_cnt++; $display("FAIL lat3_addr k=%0d got %h want 40", k, addr3); end
         vec_cnt++; if (d_done3 !== (k == 4)) begin err_cnt++; $display("FAIL lat3_done k=%0d got %b want %b", k, d_done3, (k == 4)); end
         if (k == 4) begin
            vec_cnt++; if (d_rdata3 !== 32'h13579BDF) begin err_cnt++; $display("FAIL lat3_rdata got %h want 13579bdf", d_rdata3); end
         end
      end
      @(negedge clk); #1;
      vec_cnt++; if (busy3 !== 1'b0) begin err_cnt++; $display("FAIL lat3_busy_after got %b want 0", busy3); end
   endtask

   task automatic test_reset_abort();
      @(negedge clk);
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h300; d_wdata = 32'h12345678;
      @(negedge clk);
      d_req = 1'b0; d_we = 1'b0;
      #1;
      vec_cnt++; if (we !== 1'b1) begin err_cnt++; $display("FAIL abort_we_before got %b want 1", we); end
      reset = 1'b1;
      #1;
      vec_cnt++; if ({we, d_done, busy} !== 3'b000) begin err_cnt++; $display("FAIL abort_we/done/busy got %b want 000", {we, d_done, busy}); end
      vec_cnt++; if (addr !== 32'h0) begin err_cnt++; $display("FAIL abort_addr got %h want 0", addr); end
      @(negedge clk);
      reset = 1'b0;
      vec_cnt++; if (mem[12'h0C0] !== 32'h0) begin err_cnt++; $display("FAIL abort_ram_write got %h want 0", mem[12'h0C0]); end
      @(negedge clk);
      if_req = 1'b1; if_addr = 32'h100;
      #1;
      vec_cnt++; if (if_gnt !== 1'b1) begin err_cnt++; $display("FAIL abort_next_gnt got %b want 1", if_gnt); end
      @(negedge clk);
      if_req = 1'b0;
      @(negedge clk); #1;
      vec_cnt++; if ({if_done, if_rdata} !== {1'b1, 32'h00500093})
         begin err_cnt++; $display("FAIL abort_next_done got %b/%h want 1/00500093", if_done, if_rdata); end
      @(negedge clk);
   endtask

   task automatic test_busy_ignore();
      @(negedge clk);
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2000;
      @(negedge clk);
      d_req = 1'b0; if_req = 1'b1; if_addr = 32'h100;
      #1;
      vec_cnt++; if (if_gnt !== 1'b0) begin err_cnt++; $display("FAIL busy_pulse_gnt got %b want 0", if_gnt); end
      @(negedge clk);
      if_req = 1'b0;
      @(negedge clk); #1;
      vec_cnt++; if ({busy, if_gnt} !== 2'b00) begin err_cnt++; $display("FAIL busy_pulse_lost got %b want 00", {busy, if_gnt}); end
      d_req = 1'b1; d_addr = 32'h2000;
      #1;
      @(negedge clk);
      d_req = 1'b0; if_req = 1'b1;
      #1;
      vec_cnt++; if (if_gnt !== 1'b0) begin err_cnt++; $display("FAIL busy_held_t1 got %b want 0", if_gnt); end
      @(negedge clk); #1;
      vec_cnt++; if (if_gnt !== 1'b0) begin err_cnt++; $display("FAIL busy_held_t2 got %b want 0", if_gnt); end
      @(negedge clk); #1;
      vec_cnt++; if ({busy, if_gnt} !== 2'b01) begin err_cnt++; $display("FAIL busy_held_idle got %b want 01", {busy, if_gnt}); end
      @(negedge clk);
      if_req = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   initial begin
      for (int i = 0; i < 4096; i++) begin
         mem[i]  = 32'h0;
         mem3[i] = 32'h0;
      end
      mem[12'h040]  = 32'h00500093;
      mem[12'h010]  = 32'hCAFE0001;
      mem3[12'h010] = 32'h13579BDF;
      if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
      if_req3 = 0; if_addr3 = 0; d_req3 = 0; d_we3 = 0; d_addr3 = 0; d_wdata3 = 0;
      reset = 1'b1;

      test_reset();
      test_fetch();
      test_store_load();
      test_streak();
      test_lat3();
      test_reset_abort();
      test_busy_ignore();

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule

// File: doc/riscv_mem_arbiter.md
Name: riscv_mem_arbiter

Overview:
- Shares the CPU's single RAM port (we_o/addr_o/data_i/data_o) between the instruction-fetch requester and the load/store (data) requester.
- Sits between the fetch/control units and RAM, with one transaction in flight at a time.
- Data accesses take priority over fetch. A bounded-streak rule prevents fetch starvation.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- RD_LATENCY, 1, cycles from first addr_o presentation to data_i valid; legal range 1..3.
- MAX_DATA_STREAK, 4, consecutive data grants allowed while fetch waits, before fetch is forced; legal range 1..15.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- if_req_i  in  1  fetch request (read only)
- if_addr_i  in  ADDR_W  fetch address
- if_gnt_o  out  1  fetch request accepted this cycle
- if_done_o  out  1  fetch read data valid (1-cycle pulse)
- if_rdata_o  out  DATA_W  fetch read data
- d_req_i  in  1  data request
- d_we_i  in  1  1 = store, 0 = load
- d_addr_i  in  ADDR_W  data address
- d_wdata_i  in  DATA_W  store data
- d_gnt_o  out  1  data request accepted this cycle
- d_done_o  out  1  load data valid or store committed (1-cycle pulse)
- d_rdata_o  out  DATA_W  load data
- we_o  out  1  RAM write enable
- addr_o  out  ADDR_W  RAM address
- data_o  out  DATA_W  RAM write data
- data_i  in  DATA_W  RAM read data
- busy_o  out  1  transaction in flight (state != IDLE)

Behaviour:
- Reset (async, immediate): state=IDLE, cnt=0, streak=0; we_o=0, addr_o=0, data_o=0, gnt/done=0, busy_o=0.
- A reset asserted mid-transaction aborts it. No done pulse is issued, and a write in progress is dropped (we_o deasserts immediately).
- States: IDLE, ACCESS.
- IDLE:
  - Selection is combinational: if only one req is high, it wins.
  - If both are high, data wins unless streak==MAX_DATA_STREAK, in which case fetch wins.
  - The winner's gnt_o is high the same cycle (combinational from req; only in IDLE). At most one gnt is high per cycle.
  - On grant, latch owner, addr, we (0 for fetch), wdata; then go to ACCESS with cnt=0.
- ACCESS:
  - addr_o and data_o are driven from the latched registers and held for the whole state.
  - Write: we_o=1 for exactly one cycle (cnt=0); d_done_o pulses that same cycle; next state IDLE.
  - Read: cnt increments each cycle. When cnt==RD_LATENCY, the owner's done pulses and its rdata = data_i (combinational pass-through); next state IDLE.
- Timing:
  - Read grant at cycle T gives done at T+1+RD_LATENCY; next grant possible at T+2+RD_LATENCY.
  - Write grant at T gives done at T+1; next grant at T+2.
- Streak:
  - Saturating; increments on each data grant and clears on each fetch grant.
  - Also clears on a data grant when if_req_i is low, so the streak counts only while fetch is waiting.
- In IDLE, addr_o and data_o hold their last values; we_o=0.
- rdata outputs are meaningful only while the matching done is high; otherwise they are don't-care.
- Requests arriving while busy are ignored (no gnt); requesters hold req until gnt.
- A req dropped after gnt has no effect: the transaction is already latched.
- No alignment or address checking is performed; addresses pass through unchanged.

Decomposition:
- Shared package/include riscv_mem_pkg:
  - state encodings ST_IDLE, ST_ACCESS
  - owner encodings OWN_IF=0, OWN_D=1
  - streak counter width constant
- Sub-module riscv_mem_prio: combinational requester selection plus the registered streak counter. Inputs are the two reqs, idle, and the grant event; outputs are the grant vector.
- The top level holds the FSM, latches, latency counter and RAM drive.

Test Plan:
- Single fetch, RD_LATENCY=1, if_addr_i=0x100, RAM[0x100]=0x00500093 -> if_gnt_o at T; addr_o=0x100 at T+1..T+2; if_done_o with if_rdata_o=0x00500093 at T+2; busy_o low at T+3.
- Store d_addr_i=0x2000, d_wdata_i=0xDEADBEEF -> we_o=1, addr_o=0x2000, data_o=0xDEADBEEF exactly at T+1; d_done_o at T+1; a subsequent load from 0x2000 returns 0xDEADBEEF.
- Both reqs held continuously, MAX_DATA_STREAK=4 -> grant order D,D,D,D,IF,D,D,D,D,IF; never two gnts in one cycle.
- RD_LATENCY=3, load from 0x40 -> d_done_o exactly 4 cycles after d_gnt_o; addr_o stable throughout ACCESS.
- Reset asserted in the ACCESS cycle of a store -> we_o falls asynchronously, no d_done_o, busy_o=0, addr_o=0; the next request is granted normally after reset deasserts.
- if_req_i pulses high for one cycle while busy -> no if_gnt_o; a req held until IDLE -> granted on the first IDLE cycle.
